// File: rtl/lif_pkg.sv
// Shared types and widths for the time-multiplexed LIF neuron scheduler.
package lif_pkg;
  localparam int STATE_W = 8;
  localparam logic [STATE_W-1:0] SAT_MAX = {STATE_W{1'b1}};
  localparam int REF_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } lif_state_e;
endpackage

// File: rtl/lif_update_unit.sv
// Shared combinational neuron update: leak, integrate, saturate, fire, refractory.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT    = 2
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [REF_W-1:0]   i_r,
  input  logic [STATE_W-1:0] i_in,
  input  logic [STATE_W-1:0] i_threshold,
  output logic [STATE_W-1:0] o_next_state,
  output logic [REF_W-1:0]   o_next_r,
  output logic               o_spike
);
  logic [STATE_W-1:0] w_leaked;
  logic [STATE_W:0]   w_sum;
  logic [STATE_W-1:0] w_nxt;

  always_comb begin
    w_leaked     = i_state - (i_state >> LEAK_SHIFT);
    w_sum        = {1'b0, w_leaked} + {1'b0, i_in};
    w_nxt        = w_sum[STATE_W] ? SAT_MAX : w_sum[STATE_W-1:0];
    o_next_state = '0;
    o_next_r     = '0;
    o_spike      = 1'b0;
    // A refractory neuron ignores its input and stays clamped at zero.
    if (i_r != '0) begin
      o_next_r = i_r - REF_W'(1);
    end else if (w_nxt >= i_threshold) begin
      o_spike  = 1'b1;
      o_next_r = REF_W'(REFRACT);
    end else begin
      o_next_state = w_nxt;
    end
  end
endmodule

// File: rtl/lif_scheduler.sv
// Scans NUM_NEURONS LIF neurons through one shared update unit per timestep tick
// and commits the new spike vector atomically.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int TICK_DIV    = 8,
  parameter int LEAK_SHIFT  = 2,
  parameter int REFRACT     = 2,
  parameter int WEIGHT      = 120,
  localparam int SEL_W      = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [STATE_W-1:0]     current,
  input  logic [STATE_W-1:0]     threshold,
  input  logic [SEL_W-1:0]       sel,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic [STATE_W-1:0]     state_out,
  output logic                   busy,
  output logic                   overrun,
  output lif_state_e             dbg_state
);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_NEURONS - 1);

  logic [DIV_W-1:0]       r_div;
  lif_state_e             r_fsm;
  logic [SEL_W-1:0]       r_idx;
  logic [STATE_W-1:0]     r_cur_sh;
  logic [STATE_W-1:0]     r_thr_sh;
  logic [STATE_W-1:0]     r_mem [NUM_NEURONS];
  logic [REF_W-1:0]       r_ref [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_new_spike;
  logic [NUM_NEURONS-1:0] r_spike_out;
  logic [STATE_W-1:0]     r_state_out;
  logic                   r_busy;
  logic                   r_overrun;

  logic                   w_tick;
  logic [STATE_W-1:0]     w_in;
  logic [STATE_W-1:0]     w_sel_state;
  logic [STATE_W-1:0]     w_next_state;
  logic [REF_W-1:0]       w_next_r;
  logic                   w_spike;

  assign w_tick = ena && (r_div == DIV_LAST);

  // Chain input uses the last committed spike vector, never this scan's results.
  always_comb begin
    w_in = r_cur_sh;
    if (r_idx != '0) w_in = r_spike_out[r_idx - SEL_W'(1)] ? STATE_W'(WEIGHT) : '0;
  end

  always_comb begin
    w_sel_state = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (sel == SEL_W'(k)) w_sel_state = r_mem[k];
    end
  end

  lif_update_unit #(
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT)
  ) u_update (
    .i_state      (r_mem[r_idx]),
    .i_r          (r_ref[r_idx]),
    .i_in         (w_in),
    .i_threshold  (r_thr_sh),
    .o_next_state (w_next_state),
    .o_next_r     (w_next_r),
    .o_spike      (w_spike)
  );

  // busy is high from the cycle after an accepted tick through the COMMIT cycle;
  // spike_out changes only on the edge that ends COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_fsm       <= ST_IDLE;
      r_idx       <= '0;
      r_cur_sh    <= '0;
      r_thr_sh    <= '0;
      r_new_spike <= '0;
      r_spike_out <= '0;
      r_state_out <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        r_mem[k] <= '0;
        r_ref[k] <= '0;
      end
    end else begin
      r_state_out <= w_sel_state;
      if (ena) r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      if (w_tick && (r_fsm != ST_IDLE)) r_overrun <= 1'b1;
      case (r_fsm)
        ST_IDLE: begin
          if (w_tick) begin
            r_cur_sh    <= current;
            r_thr_sh    <= threshold;
            r_idx       <= '0;
            r_new_spike <= '0;
            r_busy      <= 1'b1;
            r_fsm       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_mem[r_idx]       <= w_next_state;
          r_ref[r_idx]       <= w_next_r;
          r_new_spike[r_idx] <= w_spike;
          r_idx              <= r_idx + SEL_W'(1);
          if (r_idx == IDX_LAST) r_fsm <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_spike_out <= r_new_spike;
          r_busy      <= 1'b0;
          r_fsm       <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign spike_out = r_spike_out;
  assign state_out = r_state_out;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign dbg_state = r_fsm;
endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler: a timestep-level reference model predicts each
// committed spike vector, selected membrane state and commit cycle.
module tb_lif_scheduler;
  import lif_pkg::*;

  localparam int NUM_NEURONS = 4;
  localparam int TICK_DIV    = 8;
  localparam int LEAK_SHIFT  = 2;
  localparam int REFRACT     = 2;
  localparam int WEIGHT      = 120;
  localparam int SEL_W       = $clog2(NUM_NEURONS);
  localparam int SAT         = (1 << STATE_W) - 1;
  localparam int EXP_W       = NUM_NEURONS + STATE_W + 16;

  // clock / reset
  logic clk;
  logic rst;
  logic rst_q;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  logic                   ena;
  logic                   ena_o;
  logic [STATE_W-1:0]     current;
  logic [STATE_W-1:0]     threshold;
  logic [SEL_W-1:0]       sel;
  logic [NUM_NEURONS-1:0] spike_out, ovr_spike_out;
  logic [STATE_W-1:0]     state_out, ovr_state_out;
  logic                   busy, ovr_busy;
  logic                   overrun, ovr_overrun;
  lif_state_e             dbg_state, ovr_dbg_state;

  lif_scheduler #(
    .NUM_NEURONS (NUM_NEURONS), .TICK_DIV (TICK_DIV), .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT (REFRACT), .WEIGHT (WEIGHT)
  ) u_dut (
    .clk (clk), .rst (rst), .ena (ena), .current (current), .threshold (threshold),
    .sel (sel), .spike_out (spike_out), .state_out (state_out), .busy (busy),
    .overrun (overrun), .dbg_state (dbg_state)
  );

  // Second instance with a too-short tick period so ticks collide with scans.
  lif_scheduler #(
    .NUM_NEURONS (NUM_NEURONS), .TICK_DIV (4), .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT (REFRACT), .WEIGHT (WEIGHT)
  ) u_ovr (
    .clk (clk), .rst (rst), .ena (ena_o), .current (current), .threshold (threshold),
    .sel (sel), .spike_out (ovr_spike_out), .state_out (ovr_state_out), .busy (ovr_busy),
    .overrun (ovr_overrun), .dbg_state (ovr_dbg_state)
  );

  // scoreboard state
  logic [EXP_W-1:0]       exp_q[$];
  logic [EXP_W-1:0]       mon_e;
  logic                   prev_busy;
  int                     n_vec;
  int                     n_err;
  int                     n_edge;
  int                     ena_cnt;
  bit                     rand_mode;

  // reference model: one entry per neuron, advanced a whole timestep at a time
  int                     m_mem [NUM_NEURONS];
  int                     m_ref [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] m_spk;

  int st_tbl  [7] = '{40, 70, 93, 0, 0, 0, 40};
  int spk_tbl [7] = '{0, 0, 0, 1, 2, 4, 8};
  int sat_st  [2] = '{200, 0};
  int sat_spk [2] = '{0, 1};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_NEURONS; i++) begin
      m_mem[i] = 0;
      m_ref[i] = 0;
    end
    m_spk   = '0;
    ena_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_tick();
    logic [NUM_NEURONS-1:0] ns;
    int in_v;
    int nxt;
    ns = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      in_v = (i == 0) ? int'(current) : (m_spk[i-1] ? WEIGHT : 0);
      if (m_ref[i] > 0) begin
        m_mem[i] = 0;
        m_ref[i] = m_ref[i] - 1;
      end else begin
        nxt = m_mem[i] - m_mem[i] / (2 ** LEAK_SHIFT) + in_v;
        if (nxt > SAT) nxt = SAT;
        if (nxt >= int'(threshold)) begin
          ns[i]    = 1'b1;
          m_mem[i] = 0;
          m_ref[i] = REFRACT;
        end else begin
          m_mem[i] = nxt;
        end
      end
    end
    m_spk = ns;
    exp_q.push_back({ns, STATE_W'(m_mem[sel]), 16'(n_edge + NUM_NEURONS + 1)});
  endtask

  // driver: one clock per call, inputs changed at the falling edge
  task automatic step(input logic e);
    ena = e;
    if (rand_mode && e && !rst && ((ena_cnt + 1) % TICK_DIV == 0)) begin
      current   = STATE_W'($urandom_range(0, SAT));
      threshold = ($urandom_range(0, 7) == 0) ? '0 : STATE_W'($urandom_range(0, SAT));
      sel       = SEL_W'($urandom_range(0, NUM_NEURONS - 1));
    end
    @(posedge clk);
    n_edge++;
    if (!rst && e) begin
      ena_cnt++;
      if (ena_cnt % TICK_DIV == 0) model_tick();
    end
    @(negedge clk);
  endtask

  task automatic run_to_tick();
    do step(1'b1); while (ena_cnt % TICK_DIV != 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step(1'b1);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_spike_out", int'(spike_out), 0);
    chk("rst_state_out", int'(state_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_fsm_idle", int'(dbg_state), int'(ST_IDLE));
    chk("rst_ovr_overrun", int'(ovr_overrun), 0);
    chk("rst_ovr_outputs", int'(ovr_spike_out) + int'(ovr_state_out) + int'(ovr_busy)
        + int'(ovr_dbg_state), 0);
  endtask

  // monitor: every commit (falling busy outside reset) is matched against the queue
  initial prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_q && prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL commit_unexpected: spike_out=%b with no timestep pending", spike_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_spike", int'(spike_out), int'(mon_e[EXP_W-1 -: NUM_NEURONS]));
        chk("commit_state", int'(state_out), int'(mon_e[16 +: STATE_W]));
        chk("commit_edge", n_edge, int'(mon_e[15:0]));
        chk("commit_overrun", int'(overrun), 0);
      end
    end
    prev_busy <= busy;
  end

  initial begin
    n_vec = 0; n_err = 0; n_edge = 0; rand_mode = 1'b0;
    rst = 1'b1; ena = 1'b0; ena_o = 1'b1;
    current = '0; threshold = '0; sel = '0;
    model_reset();
    do_reset(2);
    chk_reset_outputs();

    // overrun: fast instance first ticks on its 4th edge and collides on its 8th
    repeat (7) step(1'b0);
    chk("ovr_before_collision", int'(ovr_overrun), 0);
    step(1'b0);
    chk("ovr_after_collision", int'(ovr_overrun), 1);

    // integrate / leak / fire, then propagation and refractory
    threshold = 8'd100; current = 8'd40; sel = '0;
    for (int t = 0; t < 7; t++) begin
      run_to_tick();
      repeat (NUM_NEURONS + 1) step(1'b1);
      chk("lif_state_n0", int'(state_out), st_tbl[t]);
      chk("lif_spike_vec", int'(spike_out), spk_tbl[t]);
    end
    chk("ovr_sticky", int'(ovr_overrun), 1);

    // reset in the middle of a scan
    run_to_tick();
    step(1'b1);
    step(1'b1);
    chk("midscan_busy", int'(busy), 1);
    do_reset(2);
    chk_reset_outputs();

    // saturation
    threshold = 8'd255; current = 8'd200; sel = '0;
    for (int t = 0; t < 2; t++) begin
      run_to_tick();
      repeat (NUM_NEURONS + 1) step(1'b1);
      chk("sat_state_n0", int'(state_out), sat_st[t]);
      chk("sat_spike_vec", int'(spike_out), sat_spk[t]);
    end

    // ena dropped mid-scan: scan still commits, then nothing moves
    current = 8'd30; threshold = 8'd90; sel = 2'd1;
    run_to_tick();
    step(1'b1);
    repeat (20) step(1'b0);
    chk("pause_busy", int'(busy), 0);
    chk("pause_spike", int'(spike_out), int'(m_spk));
    chk("pause_state", int'(state_out), m_mem[sel]);

    // randomized timesteps with random enable gaps
    rand_mode = 1'b1;
    repeat (600) step($urandom_range(0, 9) != 0);
    rand_mode = 1'b0;

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0);
    chk("drain_pending", exp_q.size(), 0);
    chk("main_overrun_end", int'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
